e203_exu_fpu_fma_seq: RTL

Sequencer for the fused multiply-add family (FMADD, FMSUB, FNMSUB, FNMADD) in the E203 FPU execute stage. It accepts one three-operand request at a time and drives the existing multiplier unit, then the add/sub unit, over their valid/ready handshakes. It applies RISC-V sign rules between the two steps and returns a single registered result on the FMAC write-back handshake. Flushes are tolerated at any point: any request already accepted by a unit has its response drained.

---
 rtl/e203_exu_fpu_fma_seq_pkg.sv | 49 ++++
 rtl/e203_exu_fpu_fma_sgn.sv | 25 ++
 rtl/e203_exu_fpu_fma_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/e203_exu_fpu_fma_seq_pkg.sv
// Shared types and constants for the FMA sequencer: state encoding, op codes,
// decode-info to op mapping and the registered request payload.
package e203_exu_fpu_fma_seq_pkg;

  localparam int unsigned E203_XLEN       = 32;
  localparam int unsigned E203_ITAG_WIDTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_REQ  = 3'd1,
    ST_MUL_WAIT = 3'd2,
    ST_ADD_REQ  = 3'd3,
    ST_ADD_WAIT = 3'd4,
    ST_DONE     = 3'd5,
    ST_DRAIN    = 3'd6
  } fma_state_e;

  typedef enum logic [1:0] {
    FMA_OP_FMADD  = 2'b00,
    FMA_OP_FMSUB  = 2'b01,
    FMA_OP_FNMSUB = 2'b10,
    FMA_OP_FNMADD = 2'b11
  } fma_op_e;

  // Bit positions of the FMAC group inside the decode-info bus
  localparam int unsigned E203_DECINFO_FMAC_FMADD  = 0;
  localparam int unsigned E203_DECINFO_FMAC_FMSUB  = 1;
  localparam int unsigned E203_DECINFO_FMAC_FNMSUB = 2;
  localparam int unsigned E203_DECINFO_FMAC_FNMADD = 3;
  localparam int unsigned E203_DECINFO_FMAC_W      = 4;

  typedef struct packed {
    logic [E203_XLEN-1:0]       a;
    logic [E203_XLEN-1:0]       b;
    logic [E203_XLEN-1:0]       c;
    logic [1:0]                 op;
    logic [E203_ITAG_WIDTH-1:0] itag;
  } fma_req_t;

  function automatic fma_op_e decinfo_to_fma_op(input logic [E203_DECINFO_FMAC_W-1:0] info);
    fma_op_e op;
    op = FMA_OP_FMADD;
    if (info[E203_DECINFO_FMAC_FMSUB])  op = FMA_OP_FMSUB;
    if (info[E203_DECINFO_FMAC_FNMSUB]) op = FMA_OP_FNMSUB;
    if (info[E203_DECINFO_FMAC_FNMADD]) op = FMA_OP_FNMADD;
    return op;
  endfunction

endpackage

// File: rtl/e203_exu_fpu_fma_sgn.sv
// Sign rules between the multiply and add steps, plus the zero-product shortcut
// detect (only live when E203_FMA_SEQ_ZERO_SKIP_EN is defined).
module e203_exu_fpu_fma_sgn
  import e203_exu_fpu_fma_seq_pkg::*;
(
  input  logic [1:0]           op,
  input  logic [E203_XLEN-1:0] prod,
  input  logic [E203_XLEN-1:0] addend,
  output logic [E203_XLEN-1:0] prod_c,
  output logic [E203_XLEN-1:0] addend_c,
  output logic                 skip_c
);

  // op[1] negates the product, op[0] negates the addend
  assign prod_c   = {prod[E203_XLEN-1] ^ op[1], prod[E203_XLEN-2:0]};
  assign addend_c = {addend[E203_XLEN-1] ^ op[0], addend[E203_XLEN-2:0]};

`ifdef E203_FMA_SEQ_ZERO_SKIP_EN
  // A signed-zero product leaves the addend as the exact result when it is non-zero
  assign skip_c = (prod[E203_XLEN-2:0] == '0) && (addend[E203_XLEN-2:0] != '0);
`else
  assign skip_c = 1'b0;
`endif

endmodule

// File: rtl/e203_exu_fpu_fma_seq.sv
// FMA sequencer: drives the multiplier then the adder and returns one registered
// result. Optional add-skip for zero products under E203_FMA_SEQ_ZERO_SKIP_EN.
module e203_exu_fpu_fma_seq
  import e203_exu_fpu_fma_seq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fma_i_valid,
  output logic                       fma_i_ready,
  input  logic [E203_XLEN-1:0]       fma_i_rs1,
  input  logic [E203_XLEN-1:0]       fma_i_rs2,
  input  logic [E203_XLEN-1:0]       fma_i_rs3,
  input  logic [1:0]                 fma_i_op,
  input  logic [E203_ITAG_WIDTH-1:0] fma_i_itag,
  input  logic                       flush_pulse,
  output logic                       mul_req_valid,
  input  logic                       mul_req_ready,
  output logic [E203_XLEN-1:0]       mul_req_a,
  output logic [E203_XLEN-1:0]       mul_req_b,
  input  logic                       mul_rsp_valid,
  output logic                       mul_rsp_ready,
  input  logic [E203_XLEN-1:0]       mul_rsp_dat,
  output logic                       add_req_valid,
  input  logic                       add_req_ready,
  output logic [E203_XLEN-1:0]       add_req_a,
  output logic [E203_XLEN-1:0]       add_req_b,
  input  logic                       add_rsp_valid,
  output logic                       add_rsp_ready,
  input  logic [E203_XLEN-1:0]       add_rsp_dat,
  input  logic [1:0]                 add_rsp_ovf,
  output logic                       fma_o_valid,
  input  logic                       fma_o_ready,
  output logic [E203_XLEN-1:0]       fma_o_wbck_wdat,
  output logic [E203_ITAG_WIDTH-1:0] fma_o_itag,
  output logic [1:0]                 fma_o_overflow,
  output logic                       fma_o_wbck_err
);

  fma_state_e           state, nxt_state;
  fma_req_t             req_q;
  logic [E203_XLEN-1:0] prod_q, addend_q, wdat_q;
  logic [1:0]           ovf_q;
  logic                 drain_add_q;
  logic [E203_XLEN-1:0] prod_c, addend_c;
  logic                 skip_c;
  logic                 accept_c;

  e203_exu_fpu_fma_sgn u_sgn (
    .op       (req_q.op),
    .prod     (mul_rsp_dat),
    .addend   (req_q.c),
    .prod_c   (prod_c),
    .addend_c (addend_c),
    .skip_c   (skip_c)
  );

  assign accept_c = fma_i_valid & fma_i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt_state;
  end

  // A flush with a handshake already done on a unit must drain that unit's response
  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:     if (accept_c) nxt_state = ST_MUL_REQ;
      ST_MUL_REQ: begin
        if (flush_pulse)        nxt_state = mul_req_ready ? ST_DRAIN : ST_IDLE;
        else if (mul_req_ready) nxt_state = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (mul_rsp_valid)    nxt_state = flush_pulse ? ST_IDLE : (skip_c ? ST_DONE : ST_ADD_REQ);
        else if (flush_pulse) nxt_state = ST_DRAIN;
      end
      ST_ADD_REQ: begin
        if (flush_pulse)        nxt_state = add_req_ready ? ST_DRAIN : ST_IDLE;
        else if (add_req_ready) nxt_state = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        if (add_rsp_valid)    nxt_state = flush_pulse ? ST_IDLE : ST_DONE;
        else if (flush_pulse) nxt_state = ST_DRAIN;
      end
      ST_DONE:     if (flush_pulse || fma_o_ready) nxt_state = ST_IDLE;
      ST_DRAIN:    if (drain_add_q ? add_rsp_valid : mul_rsp_valid) nxt_state = ST_IDLE;
      default:     nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    fma_i_ready   = 1'b0;
    mul_req_valid = 1'b0;
    mul_rsp_ready = 1'b0;
    add_req_valid = 1'b0;
    add_rsp_ready = 1'b0;
    fma_o_valid   = 1'b0;
    case (state)
      ST_IDLE:     fma_i_ready   = ~flush_pulse;
      ST_MUL_REQ:  mul_req_valid = 1'b1;
      ST_MUL_WAIT: mul_rsp_ready = 1'b1;
      ST_ADD_REQ:  add_req_valid = 1'b1;
      ST_ADD_WAIT: add_rsp_ready = 1'b1;
      ST_DONE:     fma_o_valid   = 1'b1;
      ST_DRAIN: begin
        mul_rsp_ready = ~drain_add_q;
        add_rsp_ready = drain_add_q;
      end
      default: ;
    endcase
  end

  // Operand, intermediate and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      prod_q      <= '0;
      addend_q    <= '0;
      wdat_q      <= '0;
      ovf_q       <= '0;
      drain_add_q <= 1'b0;
    end else begin
      if (accept_c) begin
        req_q <= '{a: fma_i_rs1, b: fma_i_rs2, c: fma_i_rs3, op: fma_i_op, itag: fma_i_itag};
      end
      if (state == ST_MUL_WAIT && mul_rsp_valid) begin
        prod_q   <= prod_c;
        addend_q <= addend_c;
        if (!flush_pulse && skip_c) begin
          wdat_q <= addend_c;
          ovf_q  <= 2'b00;
        end
      end
      if (state == ST_ADD_WAIT && add_rsp_valid && !flush_pulse) begin
        wdat_q <= add_rsp_dat;
        ovf_q  <= add_rsp_ovf;
      end
      if (nxt_state == ST_DRAIN && state != ST_DRAIN) begin
        drain_add_q <= (state == ST_ADD_REQ) || (state == ST_ADD_WAIT);
      end
    end
  end

  assign mul_req_a       = req_q.a;
  assign mul_req_b       = req_q.b;
  assign add_req_a       = prod_q;
  assign add_req_b       = addend_q;
  assign fma_o_wbck_wdat = wdat_q;
  assign fma_o_itag      = req_q.itag;
  assign fma_o_overflow  = ovf_q;
  assign fma_o_wbck_err  = 1'b0;

endmodule
